// File: rtl/fp_sub_iter.sv
// fp_sub_iter: iterative IEEE-754 single-precision a - b, one shift per cycle in align/normalise.
// Define FP_SUB_ROUND_EN to add a round-to-nearest-even state; otherwise the result is truncated.
module fp_sub_iter #(
  parameter int MAX_ALIGN = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  localparam logic [7:0] MAXA = 8'(MAX_ALIGN);
  state_t st, st_n;
  logic [27:0] ml, ms, ml_n, ms_n, sum, sh;
  logic [8:0] e, e_n;
  logic [7:0] cnt, cnt_n, ea, eb;
  logic [22:0] fa, fb;
  logic sg, sg_n, sub, sub_n, sb, a_big;
  logic [31:0] res, res_n;
`ifdef FP_SUB_ROUND_EN
  logic rnd, rnd_n;
  logic [24:0] mr;
`endif

  function automatic logic [27:0] shr(input logic [27:0] x);
    return {1'b0, x[27:2], x[1] | x[0]};
  endfunction

  // exponent 0 flushes to signed zero, 255 and above saturates to signed infinity
  function automatic logic [31:0] pack(input logic s, input logic [8:0] ex, input logic [22:0] f);
    return ex == 9'd0 ? {s, 31'b0} : ex >= 9'd255 ? {s, 8'hff, 23'b0} : {s, ex[7:0], f};
  endfunction

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = ea == 8'd0 ? 23'd0 : a[22:0];
  assign fb = eb == 8'd0 ? 23'd0 : b[22:0];
  assign sb = ~b[31];
  assign a_big = {ea, fa} >= {eb, fb};
  assign sum = sub ? ml - ms : ml + ms;
  assign sh = shr(ml);
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign result = res;
`ifdef FP_SUB_ROUND_EN
  assign mr = ml[27:3] + {24'b0, ml[2] & (ml[3] | ml[1] | ml[0])};
`endif

  always_comb begin
    st_n = st;
    ml_n = ml;
    ms_n = ms;
    e_n = e;
    cnt_n = cnt;
    sg_n = sg;
    sub_n = sub;
    res_n = res;
`ifdef FP_SUB_ROUND_EN
    rnd_n = rnd;
`endif
    case (st)
      IDLE: if (in_valid) begin
        st_n = ALIGN;
        sg_n = a_big ? a[31] : sb;
        sub_n = a[31] ^ sb;
        e_n = {1'b0, a_big ? ea : eb};
        cnt_n = a_big ? ea - eb : eb - ea;
        ml_n = a_big ? {1'b0, ea != 8'd0, fa, 3'b0} : {1'b0, eb != 8'd0, fb, 3'b0};
        ms_n = a_big ? {1'b0, eb != 8'd0, fb, 3'b0} : {1'b0, ea != 8'd0, fa, 3'b0};
`ifdef FP_SUB_ROUND_EN
        rnd_n = 1'b0;
`endif
      end
      ALIGN: begin
        st_n = cnt > 8'd1 && cnt <= MAXA ? ALIGN : ADD;
        cnt_n = cnt > MAXA || cnt == 8'd0 ? cnt : cnt - 8'd1;
        ms_n = cnt > MAXA ? {27'b0, |ms} : cnt != 8'd0 ? shr(ms) : ms;
      end
      ADD: begin
        st_n = sum == 28'd0 ? DONE : NORM;
        res_n = sum == 28'd0 ? 32'd0 : res;
        ml_n = sum;
      end
      NORM: begin
        if (ml[27]) begin
          ml_n = sh;
          e_n = e + 9'd1;
`ifdef FP_SUB_ROUND_EN
          if (rnd) begin
            res_n = pack(sg, e + 9'd1, sh[25:3]);
            st_n = DONE;
          end
`endif
        end else if (!ml[26] && e != 9'd0) begin
          ml_n = {ml[26:0], 1'b0};
          e_n = e - 9'd1;
        end
`ifdef FP_SUB_ROUND_EN
        else if (e != 9'd0 && e < 9'd255 && !rnd) st_n = ROUND;
`endif
        else begin
          res_n = pack(sg, e, ml[25:3]);
          st_n = DONE;
        end
      end
`ifdef FP_SUB_ROUND_EN
      // a rounding carry goes back for a single right shift, then packs directly
      ROUND: if (mr[24]) begin
        ml_n = {mr, 3'b0};
        rnd_n = 1'b1;
        st_n = NORM;
      end else begin
        res_n = {sg, e[7:0], mr[22:0]};
        st_n = DONE;
      end
`endif
      DONE: st_n = out_ready ? IDLE : DONE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      ml <= '0;
      ms <= '0;
      e <= '0;
      cnt <= '0;
      sg <= 1'b0;
      sub <= 1'b0;
      res <= '0;
`ifdef FP_SUB_ROUND_EN
      rnd <= 1'b0;
`endif
    end else begin
      st <= st_n;
      ml <= ml_n;
      ms <= ms_n;
      e <= e_n;
      cnt <= cnt_n;
      sg <= sg_n;
      sub <= sub_n;
      res <= res_n;
`ifdef FP_SUB_ROUND_EN
      rnd <= rnd_n;
`endif
    end
  end
endmodule

// File: tb/tb_fp_sub_iter.sv
// tb_fp_sub_iter: directed and randomized checks of fp_sub_iter against a behavioural model.
module tb_fp_sub_iter;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic in_ready, out_valid;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fp_sub_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

`ifdef FP_SUB_ROUND_EN
  localparam logic [31:0] R27 = 32'h4D000000, R31 = 32'h4F000000;
  localparam int LAT0 = 5;
`else
  localparam logic [31:0] R27 = 32'h4CFFFFFF, R31 = 32'h4EFFFFFF;
  localparam int LAT0 = 4;
`endif

  localparam int ND = 13;
  logic [31:0] tx [ND] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                           32'h4B800000, 32'h4B800000, 32'h3F800001, 32'h3F800003, 32'h00800001,
                           32'h00800000, 32'h4D000000, 32'h4F000000};
  logic [31:0] ty [ND] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'hFF7FFFFF,
                           32'h3F800000, 32'h00400000, 32'h33800000, 32'h33800000, 32'h00800000,
                           32'h00800001, 32'h3F800000, 32'h3F800000};
  logic [31:0] tr [ND] = '{32'h40000000, 32'h00000000, 32'hBF800000, 32'h40000000, 32'h7F800000,
                           32'h4B7FFFFF, 32'h4B800000, 32'h3F800000, 32'h3F800002, 32'h00000000,
                           32'h80000000, R27, R31};

  // Value-level reference: sticky alignment, exact add/sub, leading-one normalise, optional RNE.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output int lat);
    logic [7:0] ex, ey, el, es;
    logic [22:0] fx, fy;
    logic sx, sy, sl, ss;
    logic [27:0] ml, ms, sm;
    logic [24:0] mt;
    int d, e, nal;
    ex = x[30:23]; ey = y[30:23];
    fx = ex == 0 ? 23'd0 : x[22:0];
    fy = ey == 0 ? 23'd0 : y[22:0];
    sx = x[31]; sy = ~y[31];
    if ({ex, fx} >= {ey, fy}) begin
      sl = sx; el = ex; ml = {1'b0, ex != 0, fx, 3'b0};
      ss = sy; es = ey; ms = {1'b0, ey != 0, fy, 3'b0};
    end else begin
      sl = sy; el = ey; ml = {1'b0, ey != 0, fy, 3'b0};
      ss = sx; es = ex; ms = {1'b0, ex != 0, fx, 3'b0};
    end
    d = int'(el) - int'(es);
    if (d > 27) begin
      ms = {27'b0, ms != 0};
      nal = 1;
    end else begin
      ms = (ms >> d) | {27'b0, (ms & ((28'd1 << d) - 28'd1)) != 0};
      nal = d == 0 ? 1 : d;
    end
    sm = sl == ss ? ml + ms : ml - ms;
    lat = nal + 2;
    if (sm == 0) begin
      r = 32'd0;
      return;
    end
    e = int'(el);
    lat++;
    if (sm[27]) begin
      sm = (sm >> 1) | {27'b0, sm[0]};
      e++;
      lat++;
    end else
      while (!sm[26] && e > 0) begin
        sm = sm << 1;
        e--;
        lat++;
      end
    mt = sm[27:3];
`ifdef FP_SUB_ROUND_EN
    if (e > 0 && e < 255) begin
      lat++;
      if (sm[2] && (sm[3] || sm[1:0] != 0)) mt++;
      if (mt[24]) begin
        mt = mt >> 1;
        e++;
        lat++;
      end
    end
`endif
    r = e <= 0 ? {sl, 31'b0} : e >= 255 ? {sl, 8'hFF, 23'b0} : {sl, 8'(e), mt[22:0]};
  endfunction

  // Issues one operation, scribbles on a/b with in_valid high while busy, waits for out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r,
                        output int lat, output bit rdy_seen, output bit to);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    lat = 1; rdy_seen = 1'b0;
    a = $urandom; b = $urandom;
    while (!out_valid && lat < 200) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
      a = $urandom; b = $urandom;
    end
    in_valid = 1'b0;
    rdy_seen |= in_ready;
    to = !out_valid;
    r = result;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] r, mr;
    int lat, ml;
    bit rs, to;
    for (int i = 0; i < ND; i++) begin
      model(tx[i], ty[i], mr, ml);
      run_op(tx[i], ty[i], r, lat, rs, to);
      checks += 3;
      if (to || r !== tr[i]) begin errors++; $display("FAIL dir%0d_result %h-%h got %h want %h", i, tx[i], ty[i], r, tr[i]); end
      if (lat != ml) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ml); end
      if (rs) begin errors++; $display("FAIL dir%0d_in_ready_busy got 1 want 0", i); end
      if (i == 0) begin
        checks++;
        if (lat != LAT0) begin errors++; $display("FAIL dir0_abs_latency got %0d want %0d", lat, LAT0); end
      end
      finish_op();
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_post_valid got %b want 0", i, out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_post_ready got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int lat;
    bit rs, to;
    run_op(32'h40400000, 32'h3F800000, r, lat, rs, to);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
      if (result !== 32'h40000000) begin errors++; $display("FAIL bp%0d_result got %h want 40000000", i, result); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, mr;
    int lat, ml;
    bit rs, to;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'h49800000; b = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1 reset = 1'b0;
    model(32'h49800000, 32'h3F800000, mr, ml);
    run_op(32'h49800000, 32'h3F800000, r, lat, rs, to);
    checks += 2;
    if (to || r !== 32'h497FFFF0) begin errors++; $display("FAIL rstmid_next_result got %h want 497ffff0", r); end
    if (lat != ml) begin errors++; $display("FAIL rstmid_next_latency got %0d want %0d", lat, ml); end
    finish_op();
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, mr;
    int ex, ey, lat, ml;
    bit rs, to;
    for (int i = 0; i < 300; i++) begin
      ex = $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 254));
      ey = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 254)) : ex + int'($urandom_range(0, 6)) - 3;
      ey = ey < 0 ? 0 : ey > 254 ? 254 : ey;
      x = {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
      y = {1'($urandom_range(0, 1)), 8'(ey), 23'($urandom)};
      if ($urandom_range(0, 15) == 0) y = {1'($urandom_range(0, 1)), x[30:0]};
      model(x, y, mr, ml);
      run_op(x, y, r, lat, rs, to);
      checks += 3;
      if (to || r !== mr) begin errors++; $display("FAIL rnd%0d_result %h-%h got %h want %h", i, x, y, r, mr); end
      if (lat != ml) begin errors++; $display("FAIL rnd%0d_latency %h-%h got %0d want %0d", i, x, y, lat, ml); end
      if (rs) begin errors++; $display("FAIL rnd%0d_in_ready_busy got 1 want 0", i); end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
